// File: rtl/serial_word_loader.sv
// MSB-first serial-to-parallel loader: assembles K-bit frames and strobes `load` with the new `word`.
// Optional even-parity bit per frame when SERIAL_WORD_LOADER_PARITY_EN is defined.
module serial_word_loader #(
  parameter int K = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sin,
  input  logic         sen,
  output logic [K-1:0] word,
  output logic         load,
  output logic         busy,
  output logic         abort,
  output logic         perr
);

  localparam int CW = $clog2(K + 1);
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
`ifdef SERIAL_WORD_LOADER_PARITY_EN
    PARITY,
`endif
    DONE
  } state_t;

  state_t         state, state_next;
  logic [CW-1:0]  count, count_next;
  logic [K-1:0]   shreg, shreg_next, word_next;
  logic [K-1:0]   shifted;
  logic           abort_next, perr_next;

  assign shifted = {shreg[K-2:0], sin};

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_next = state;
    count_next = count;
    shreg_next = shreg;
    word_next  = word;
    abort_next = 1'b0;
    perr_next  = 1'b0;
    case (state)
      // DONE behaves like IDLE so a following frame can start with no gap cycle.
      IDLE, DONE: begin
        if (sen) begin
          shreg_next = {{(K-1){1'b0}}, sin};
          count_next = CW'(1);
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        if (!sen) begin
          abort_next = 1'b1;
          state_next = IDLE;
        end else begin
          shreg_next = shifted;
          count_next = count + CW'(1);
          if (count == LAST) begin
`ifdef SERIAL_WORD_LOADER_PARITY_EN
            state_next = PARITY;
`else
            word_next  = shifted;
            state_next = DONE;
`endif
          end
        end
      end
`ifdef SERIAL_WORD_LOADER_PARITY_EN
      PARITY: begin
        if (!sen) begin
          abort_next = 1'b1;
          state_next = IDLE;
        end else if ((^shreg ^ sin) == 1'b0) begin
          word_next  = shreg;
          state_next = DONE;
        end else begin
          perr_next  = 1'b1;
          state_next = IDLE;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the shift register is plain flops, so it is reset along with the rest of the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
      shreg <= '0;
      word  <= '0;
      abort <= 1'b0;
      perr  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state <= state_next;
      count <= count_next;
      shreg <= shreg_next;
      word  <= word_next;
      abort <= abort_next;
      perr  <= perr_next;
    end
  end

  // Decoded from the state register, so these stay free of input-to-output paths.
  assign load = (state == DONE);
`ifdef SERIAL_WORD_LOADER_PARITY_EN
  assign busy = (state == SHIFT) || (state == PARITY);
`else
  assign busy = (state == SHIFT);
`endif

endmodule

// File: tb/tb_serial_word_loader.sv
// Self-checking bench for serial_word_loader (K=4): directed frames, aborts, resets and random frames.
// Follows SERIAL_WORD_LOADER_PARITY_EN the same way as the design.
module tb_serial_word_loader;

  localparam int K = 4;
`ifdef SERIAL_WORD_LOADER_PARITY_EN
  localparam int L = K + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int L = K;
  localparam bit PAR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         sin;
  logic         sen;
  logic [K-1:0] word;
  logic         load, busy, abort, perr;

  int           total = 0;
  int           bad = 0;
  logic [K-1:0] exp_word;

  serial_word_loader #(.K(K)) dut (
    .clk   (clk),
    .reset (reset),
    .sin   (sin),
    .sen   (sen),
    .word  (word),
    .load  (load),
    .busy  (busy),
    .abort (abort),
    .perr  (perr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_outs(input string tag, input logic ld, input logic bs,
                          input logic ab, input logic pe);
    check({tag, ".load"},  32'(load),  32'(ld));
    check({tag, ".busy"},  32'(busy),  32'(bs));
    check({tag, ".abort"}, 32'(abort), 32'(ab));
    check({tag, ".perr"},  32'(perr),  32'(pe));
    check({tag, ".word"},  32'(word),  32'(exp_word));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sen = 1'b0;
      sin = 1'($urandom);
      @(posedge clk);
      #1;
      exp_outs("idle", 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // Sends the first nbits of a frame (data MSB first, then parity); drops sen if incomplete.
  task automatic send(input string tag, input logic [K-1:0] data, input int nbits,
                      input bit bad_par);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      sen = 1'b1;
      sin = (i < K) ? data[K-1-i] : (^data ^ bad_par);
      @(posedge clk);
      #1;
      if (i < L - 1) begin
        exp_outs(tag, 1'b0, 1'b1, 1'b0, 1'b0);
      end else if (PAR && bad_par) begin
        exp_outs({tag, ".perr"}, 1'b0, 1'b0, 1'b0, 1'b1);
      end else begin
        exp_word = data;
        exp_outs({tag, ".done"}, 1'b1, 1'b0, 1'b0, 1'b0);
      end
    end
    if (nbits < L) begin
      @(negedge clk);
      sen = 1'b0;
      sin = 1'($urandom);
      @(posedge clk);
      #1;
      exp_outs({tag, ".abort"}, 1'b0, 1'b0, 1'b1, 1'b0);
    end
  endtask

  initial begin
    logic [K-1:0] d;
    int           n;
    bit           bp;

    reset    = 1'b0;
    sen      = 1'b0;
    sin      = 1'b0;
    exp_word = '0;
    repeat (2) @(posedge clk);
    #1;
    exp_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    idle(2);

    send("single", 4'hB, L, 1'b0);
    idle(2);

    send("early_abort", 4'h5, 2, 1'b0);
    idle(1);

    send("b2b_a", 4'hA, L, 1'b0);
    send("b2b_6", 4'h6, L, 1'b0);
    idle(2);

`ifdef SERIAL_WORD_LOADER_PARITY_EN
    send("par_good", 4'hB, L, 1'b0);
    idle(1);
    send("par_bad", 4'h4, L, 1'b1);
    idle(1);
    send("par_abort", 4'h9, K, 1'b0);
    idle(1);
`endif

    // Reset two bits into a frame: no abort, word cleared, next frame loads normally.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      sen = 1'b1;
      sin = 1'b1;
      @(posedge clk);
      #1;
      exp_outs("pre_reset", 1'b0, 1'b1, 1'b0, 1'b0);
    end
    @(negedge clk);
    #2;
    reset = 1'b0;
    sen   = 1'b0;
    #1;
    exp_word = '0;
    exp_outs("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    idle(2);
    send("post_reset", 4'h3, L, 1'b0);
    idle(1);

    for (int f = 0; f < 30; f++) begin
      d  = K'($urandom);
      n  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, L - 1) : L;
      bp = PAR && ($urandom_range(0, 3) == 0);
      send("rand", d, n, bp);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
